// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - free-running raster timing generator (default 1280x720p60)
//
// Purpose: horizontal/vertical pixel counters plus HSYNC, VSYNC, data-enable
// and frame-start strobes. The active picture begins at counter value (0,0),
// so (o_hcnt, o_vcnt) are directly the pixel coordinates.
//
// Optional macro: VTG_PIPE_EN -- strobes pass through a PIPE_DLY-stage delay
// line and lag the counters by exactly PIPE_DLY clocks.
//
// Ports:
//   i_clk_74M      in   pixel clock
//   i_rst_n        in   asynchronous active-low reset
//   i_en           in   count enable; low freezes all state
//   o_hcnt[11:0]   out  horizontal counter, 0..H_TOTAL-1
//   o_vcnt[11:0]   out  vertical counter, 0..V_TOTAL-1
//   o_hsync        out  horizontal sync, asserted level H_POL
//   o_vsync        out  vertical sync, asserted level V_POL
//   o_de           out  high inside the active picture
//   o_frame_start  out  high while counters are (0,0)
module video_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1,
  parameter int PIPE_DLY = 2
) (
  input  logic        i_clk_74M,
  input  logic        i_rst_n,
  input  logic        i_en,
  output logic [11:0] o_hcnt,
  output logic [11:0] o_vcnt,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_de,
  output logic        o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_total
      $error("video_timing_gen: H_TOTAL and V_TOTAL must not exceed 4096");
    end
  endgenerate

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

  // 13-bit bounds so a parameter equal to 4096 still compares correctly.
  localparam logic [12:0] H_ACT_B = 13'(H_ACTIVE);
  localparam logic [12:0] H_SS_B  = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] H_SE_B  = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] V_ACT_B = 13'(V_ACTIVE);
  localparam logic [12:0] V_SS_B  = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] V_SE_B  = 13'(V_ACTIVE + V_FP + V_SYNC);

  // Strobe vector layout: {hsync, vsync, de, frame_start}.
  localparam logic [3:0] STRB_IDLE = {~H_POL, ~V_POL, 2'b00};

  logic [11:0] hcnt_q, hcnt_d;
  logic [11:0] vcnt_q, vcnt_d;
  logic [3:0]  strb_q, strb_d;
  logic [12:0] hx, vx;
  logic        hs_act, vs_act;

  always_comb begin
    hcnt_d = hcnt_q + 12'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? 12'd0 : vcnt_q + 12'd1;
    end

    // Strobes derive from the next counter values so that, once registered,
    // they line up with the counters in the same cycle. vcnt only moves at
    // the line boundary, so VSYNC edges fall on hcnt==0 by construction.
    hx     = {1'b0, hcnt_d};
    vx     = {1'b0, vcnt_d};
    hs_act = (hx >= H_SS_B) && (hx < H_SE_B);
    vs_act = (vx >= V_SS_B) && (vx < V_SE_B);
    strb_d = {H_POL ? hs_act : ~hs_act,
              V_POL ? vs_act : ~vs_act,
              (hx < H_ACT_B) && (vx < V_ACT_B),
              (hcnt_d == 12'd0) && (vcnt_d == 12'd0)};
  end

  always_ff @(posedge i_clk_74M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      strb_q <= STRB_IDLE;
    end else if (i_en) begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      strb_q <= strb_d;
    end
  end

  assign o_hcnt = hcnt_q;
  assign o_vcnt = vcnt_q;

`ifdef VTG_PIPE_EN
  generate
    if (PIPE_DLY < 1 || PIPE_DLY > 8) begin : g_bad_dly
      $error("video_timing_gen: PIPE_DLY must be in 1..8");
    end
  endgenerate

  // Stage i lags the counter-aligned strobes by i+1 clocks.
  logic [3:0] pipe_q [PIPE_DLY];

  always_ff @(posedge i_clk_74M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < PIPE_DLY; i++) pipe_q[i] <= STRB_IDLE;
    end else if (i_en) begin
      pipe_q[0] <= strb_q;
      for (int i = 1; i < PIPE_DLY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign {o_hsync, o_vsync, o_de, o_frame_start} = pipe_q[PIPE_DLY-1];
`else
  assign {o_hsync, o_vsync, o_de, o_frame_start} = strb_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - directed self-checking bench for video_timing_gen
module tb_video_timing_gen;

`ifdef VTG_PIPE_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  logic        clk;
  logic        rst_n, rst720_n, en, en720;
  logic [11:0] hcnt, vcnt, h7, v7;
  logic        hs, vs, de, fs;
  logic        hs7, vs7, de7, fs7;
  int          n_cmp, n_err;

  // Small raster: H 8/2/2/2 (14 clocks), V 4/1/1/1 (7 lines), 98 clocks/frame.
  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .PIPE_DLY(2)
  ) u_dut (
    .i_clk_74M(clk), .i_rst_n(rst_n), .i_en(en),
    .o_hcnt(hcnt), .o_vcnt(vcnt), .o_hsync(hs), .o_vsync(vs),
    .o_de(de), .o_frame_start(fs)
  );

  // Default 720p raster.
  video_timing_gen #(.PIPE_DLY(2)) u_dut720 (
    .i_clk_74M(clk), .i_rst_n(rst720_n), .i_en(en720),
    .o_hcnt(h7), .o_vcnt(v7), .o_hsync(hs7), .o_vsync(vs7),
    .o_de(de7), .o_frame_start(fs7)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected {hsync, vsync, de, frame_start} after k enabled clocks of the
  // small raster (k<=0 is reset state: everything inactive).
  function automatic logic [3:0] exp_strb(input int k);
    int h, v;
    if (k <= 0) return 4'b0000;
    h = k % 14;
    v = (k / 14) % 7;
    return {(h >= 10) && (h < 12), v == 5, (h < 8) && (v < 4), (h == 0) && (v == 0)};
  endfunction

  task automatic chk_small(input int k);
    logic [3:0] s;
    s = exp_strb(k - D);
    check("hcnt",  32'(hcnt), k % 14);
    check("vcnt",  32'(vcnt), (k / 14) % 7);
    check("hsync", 32'(hs),   32'(s[3]));
    check("vsync", 32'(vs),   32'(s[2]));
    check("de",    32'(de),   32'(s[1]));
    check("fs",    32'(fs),   32'(s[0]));
  endtask

  initial begin
    int fs_cnt, fs_last;
    int de_cnt, hs_cnt, vs_cnt, first_h;
    bit hs_seen;
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; rst720_n = 1'b0; en = 1'b1; en720 = 1'b1;
    fs_cnt = 0; fs_last = 0;
    repeat (2) @(negedge clk);
    chk_small(0);
    rst_n = 1'b1;

    // Two frames plus most of a third, stopping at (13,6).
    for (int k = 1; k <= 293; k++) begin
      @(negedge clk);
      chk_small(k);
      if (fs) begin
        fs_cnt++;
        if (fs_last > 0) check("fs_period", 32'(k - fs_last), 98);
        fs_last = k;
      end
    end
    check("fs_count", 32'(fs_cnt), 2);

    // Freeze for 5 clocks at (13,6).
    en = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk_small(293);
    end
    en = 1'b1;
    for (int k = 294; k <= 327; k++) begin
      @(negedge clk);
      chk_small(k);
    end

    // Asynchronous reset mid-line at (5,2), between clock edges.
    #2 rst_n = 1'b0;
    #1 chk_small(0);
    @(negedge clk);
    chk_small(0);
    rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      chk_small(k);
    end

    // 720p: check the second line in full.
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; first_h = -1; hs_seen = 1'b0;
    rst720_n = 1'b1;
    for (int k = 1; k <= 3305; k++) begin
      @(negedge clk);
      if (k == 1649) begin
        check("h720_end", 32'(h7), 1649);
        check("v720_l0",  32'(v7), 0);
      end
      if (k >= 1650 && k < 3300) begin
        check("h720", 32'(h7), k - 1650);
        check("v720", 32'(v7), 1);
      end
      if (k == 3300) check("v720_l2", 32'(v7), 2);
      if (k >= 1650 + D && k < 3300 + D) begin
        de_cnt += int'(de7);
        hs_cnt += int'(hs7);
        vs_cnt += int'(vs7);
        if (hs7 && !hs_seen) begin
          hs_seen = 1'b1;
          first_h = int'(h7);
        end
      end
    end
    check("de720_cnt",   32'(de_cnt),  1280);
    check("hs720_cnt",   32'(hs_cnt),  40);
    check("hs720_start", 32'(first_h), 1390 + D);
    check("vs720_cnt",   32'(vs_cnt),  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
